// File: rtl/continuous_monitoring_system_pkg.sv
// continuous_monitoring_system_pkg: control-port types, register map, reset values and arbiter FSM states
package continuous_monitoring_system_pkg;
  localparam int CTRL_ADDR_WIDTH = 32;
  localparam int CTRL_DATA_WIDTH = 32;
  localparam int NUM_CTRL_ADDRS = 4;
  localparam int CTRL_IDX_WIDTH = $clog2(NUM_CTRL_ADDRS);
  typedef logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr_t;
  localparam ctrl_addr_t CTRL_ADDR_BASE = 32'h8000_0000;
  localparam ctrl_addr_t TRIGGER_TRACE_START_ADDRESS = 32'h8000_0000;
  localparam ctrl_addr_t TRIGGER_TRACE_END_ADDRESS = 32'h8000_0004;
  localparam ctrl_addr_t MONITORED_ADDRESS_RANGE_LOWER_BOUND = 32'h8000_0008;
  localparam ctrl_addr_t MONITORED_ADDRESS_RANGE_UPPER_BOUND = 32'h8000_000C;
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} cms_arb_state_t;
  function automatic ctrl_addr_t ctrl_addr_of(input int i);
    return CTRL_ADDR_BASE + ctrl_addr_t'(i * 4);
  endfunction
  function automatic logic [CTRL_IDX_WIDTH-1:0] ctrl_addr_idx(input ctrl_addr_t a);
    return a[CTRL_IDX_WIDTH+1:2];
  endfunction
  function automatic logic [CTRL_DATA_WIDTH-1:0] ctrl_reset_value(input ctrl_addr_t a);
    return (a == MONITORED_ADDRESS_RANGE_UPPER_BOUND || a == TRIGGER_TRACE_END_ADDRESS) ? '1 : '0;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at/after ptr (one-hot grant, index, any)
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
  end
  assign any = |req;
  assign gnt = any ? N'(1) << idx : '0;
endmodule

// File: rtl/cms_ctrl_arbiter.sv
// cms_ctrl_arbiter: round-robin/lockable arbiter of NUM_REQ valid/ready write beats onto the ctrl write port; CMS_CTRL_ARB_READBACK_EN adds rb_addr/rb_data shadow readback
module cms_ctrl_arbiter
  import continuous_monitoring_system_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WRITE_GAP = 0,
  parameter int LOCK_TIMEOUT = 16,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  ctrl_addr_t                 req_addr [NUM_REQ],
  input  logic [CTRL_DATA_WIDTH-1:0] req_wdata [NUM_REQ],
  input  logic [NUM_REQ-1:0]         req_lock,
  output ctrl_addr_t                 ctrl_addr,
  output logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
  output logic                       ctrl_write_enable,
  output logic                       busy,
  output logic                       lock_active,
  output logic [IW-1:0]              lock_owner,
  output logic [31:0]                write_count
`ifdef CMS_CTRL_ARB_READBACK_EN
  ,
  input  ctrl_addr_t                 rb_addr,
  output logic [CTRL_DATA_WIDTH-1:0] rb_data
`endif
);
  localparam int TW = LOCK_TIMEOUT > 1 ? $clog2(LOCK_TIMEOUT) : 1;
  cms_arb_state_t state_q, state_d;
  logic [3:0] gap_q, gap_d;
  logic [IW-1:0] ptr_q, ptr_d, owner_q, owner_d, win;
  logic lock_q, lock_d;
  logic [TW-1:0] lcnt_q, lcnt_d;
  ctrl_addr_t addr_q, addr_d;
  logic [CTRL_DATA_WIDTH-1:0] data_q, data_d;
  logic [31:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] mask, gnt;
  logic any, accept, starve;
  assign mask = lock_q ? req_valid & (NUM_REQ'(1) << owner_q) : req_valid;
  rr_arbiter #(.N(NUM_REQ), .W(IW)) u_rr (.req(mask), .ptr(ptr_q), .gnt(gnt), .idx(win), .any(any));
  assign accept = state_q == IDLE && any;
  assign starve = state_q == IDLE && lock_q && !req_valid[owner_q] && LOCK_TIMEOUT != 0;
  assign req_ready = accept ? gnt : '0;
  assign ctrl_write_enable = state_q == ISSUE;
  assign busy = state_q != IDLE;
  assign lock_active = lock_q;
  assign lock_owner = owner_q;
  assign ctrl_addr = addr_q;
  assign ctrl_wdata = data_q;
  assign write_count = cnt_q;
  always_comb begin
    state_d = state_q;
    gap_d = gap_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    lock_d = lock_q;
    lcnt_d = lcnt_q;
    addr_d = addr_q;
    data_d = data_q;
    cnt_d = cnt_q;
    if (accept) begin
      state_d = ISSUE;
      addr_d = req_addr[win];
      data_d = req_wdata[win];
      ptr_d = IW'((int'(win) + 1) % NUM_REQ);
      lock_d = req_lock[win];
      owner_d = req_lock[win] ? win : '0;
      lcnt_d = '0;
    end else if (starve) begin
      lcnt_d = lcnt_q == TW'(LOCK_TIMEOUT - 1) ? '0 : lcnt_q + 1'b1;
      lock_d = lcnt_q != TW'(LOCK_TIMEOUT - 1);
      owner_d = lcnt_q == TW'(LOCK_TIMEOUT - 1) ? '0 : owner_q;
    end
    if (state_q == ISSUE) begin
      cnt_d = cnt_q + 32'd1;
      state_d = WRITE_GAP == 0 ? IDLE : GAP;
      gap_d = 4'(WRITE_GAP > 0 ? WRITE_GAP - 1 : 0);
    end
    if (state_q == GAP) begin
      gap_d = gap_q - 4'd1;
      state_d = gap_q == 4'd0 ? IDLE : GAP;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q <= '0;
      ptr_q <= '0;
      owner_q <= '0;
      lock_q <= 1'b0;
      lcnt_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q <= gap_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      lock_q <= lock_d;
      lcnt_q <= lcnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef CMS_CTRL_ARB_READBACK_EN
  logic [CTRL_DATA_WIDTH-1:0] shadow_q [NUM_CTRL_ADDRS];
  logic [CTRL_DATA_WIDTH-1:0] shadow_d [NUM_CTRL_ADDRS];
  always_comb begin
    shadow_d = shadow_q;
    if (ctrl_write_enable) shadow_d[ctrl_addr_idx(addr_q)] = data_q;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CTRL_ADDRS; i++)
      shadow_q[i] <= rst ? ctrl_reset_value(ctrl_addr_of(i)) : shadow_d[i];
  end
  assign rb_data = shadow_q[ctrl_addr_idx(rb_addr)];
`endif
endmodule
